// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between execute and a word-aligned memory bus.
// It aligns and masks stores, aligns and extends load data, flags illegal and
// misaligned requests, and enforces an ack timeout on the req/ack handshake.
module lsu_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_load,
  input  logic                req_store,
  input  logic [6:0]          rd_mem_op,
  input  logic [1:0]          st_size,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wmask,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                st_done,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam int NB  = XLEN / 8;
  localparam int LSB = $clog2(NB);
  localparam int CW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] E_MISALIGN = 2'b01;
  localparam logic [1:0] E_TIMEOUT  = 2'b10;
  localparam logic [1:0] E_ILLEGAL  = 2'b11;

  // True when exactly one bit of the load-type vector is set.
  function automatic logic is_onehot7(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [6:0]      r_op;
  logic [LSB-1:0]  r_lane;
  logic            r_is_load;
  logic [4:0]      r_rd;

  logic            r_req_ready;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [NB-1:0]   r_mem_wmask;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_st_done;
  logic            r_err;
  logic [1:0]      r_err_code;

  logic [1:0]      w_size;
  logic            w_illegal;
  logic            w_misaligned;
  logic [XLEN-1:0] w_wdata;
  logic [NB-1:0]   w_mask_base;
  logic [NB-1:0]   w_wmask;
  logic [LSB-1:0]  w_lane;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_ld_data;

  // Decode the incoming request: access size, legality, alignment, store lanes.
  always_comb begin
    w_size       = 2'd0;
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    w_wdata      = '0;
    w_mask_base  = '0;
    w_wmask      = '0;
    w_lane       = req_addr[LSB-1:0];

    if (req_load == req_store) begin
      w_illegal = 1'b1;
    end else if (req_load) begin
      if (!is_onehot7(rd_mem_op)) begin
        w_illegal = 1'b1;
      end else if ((rd_mem_op[0] || rd_mem_op[4]) && (XLEN == 32)) begin
        w_illegal = 1'b1;
      end else begin
        w_illegal = 1'b0;
      end
      if (rd_mem_op[0]) begin
        w_size = 2'd3;
      end else if (rd_mem_op[1] || rd_mem_op[4]) begin
        w_size = 2'd2;
      end else if (rd_mem_op[2] || rd_mem_op[5]) begin
        w_size = 2'd1;
      end else begin
        w_size = 2'd0;
      end
    end else begin
      w_size = st_size;
      if ((st_size == 2'd3) && (XLEN == 32)) begin
        w_illegal = 1'b1;
      end else begin
        w_illegal = 1'b0;
      end
    end

    case (w_size)
      2'd1:    w_misaligned = req_addr[0];
      2'd2:    w_misaligned = (req_addr[1:0] != 2'b00);
      2'd3:    w_misaligned = (req_addr[2:0] != 3'b000);
      default: w_misaligned = 1'b0;
    endcase

    // Store data is replicated so every lane of its size carries the value.
    case (st_size)
      2'd0: begin
        w_wdata     = {NB{req_wdata[7:0]}};
        w_mask_base = NB'(8'h01);
      end
      2'd1: begin
        w_wdata     = {(NB/2){req_wdata[15:0]}};
        w_mask_base = NB'(8'h03);
      end
      2'd2: begin
        w_wdata     = {(NB/4){req_wdata[31:0]}};
        w_mask_base = NB'(8'h0F);
      end
      default: begin
        w_wdata     = req_wdata;
        w_mask_base = {NB{1'b1}};
      end
    endcase

    if (req_store) begin
      w_wmask = w_mask_base << w_lane;
    end else begin
      w_wmask = '0;
      w_wdata = '0;
    end
  end

  // Align returned read data to bit 0 and extend it according to the load type.
  always_comb begin
    w_shifted = mem_rdata >> {r_lane, 3'b000};
    w_ld_data = '0;
    if (r_op[0]) begin
      w_ld_data = w_shifted;
    end else if (r_op[1]) begin
      w_ld_data = XLEN'($signed(w_shifted[31:0]));
    end else if (r_op[2]) begin
      w_ld_data = XLEN'($signed(w_shifted[15:0]));
    end else if (r_op[3]) begin
      w_ld_data = XLEN'($signed(w_shifted[7:0]));
    end else if (r_op[4]) begin
      w_ld_data = XLEN'(w_shifted[31:0]);
    end else if (r_op[5]) begin
      w_ld_data = XLEN'(w_shifted[15:0]);
    end else if (r_op[6]) begin
      w_ld_data = XLEN'(w_shifted[7:0]);
    end else begin
      w_ld_data = '0;
    end
  end

  // Sequencer: accept, hold the bus request until ack or timeout, then report.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= 7'd0;
      r_lane      <= '0;
      r_is_load   <= 1'b0;
      r_rd        <= 5'd0;
      r_req_ready <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= '0;
      r_st_done   <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      // Status outputs are single-cycle pulses unless re-armed below.
      r_wb_valid <= 1'b0;
      r_st_done  <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            r_op        <= rd_mem_op;
            r_lane      <= w_lane;
            r_is_load   <= req_load;
            r_rd        <= req_rd;
            r_cnt       <= '0;
            if (w_illegal) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= E_ILLEGAL;
            end else if (w_misaligned) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= E_MISALIGN;
            end else begin
              r_state     <= S_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_store;
              r_mem_addr  <= {req_addr[XLEN-1:LSB], {LSB{1'b0}}};
              r_mem_wdata <= w_wdata;
              r_mem_wmask <= w_wmask;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end

        S_REQ: begin
          if (mem_ack) begin
            r_state     <= S_RESP;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wmask <= '0;
            r_cnt       <= '0;
            if (r_is_load) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= w_ld_data;
            end else begin
              r_st_done <= 1'b1;
            end
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            // Last allowed cycle passed without ack: give up the bus.
            r_state     <= S_ERR;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wmask <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b1;
            r_err_code  <= E_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end

        S_ERR: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_mem_req   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign st_done   = r_st_done;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one XLEN=64 and one XLEN=32 instance, both with TIMEOUT=4.
module tb_lsu_ctrl;

  localparam logic [6:0] OP_LD  = 7'h01;
  localparam logic [6:0] OP_LW  = 7'h02;
  localparam logic [6:0] OP_LH  = 7'h04;
  localparam logic [6:0] OP_LB  = 7'h08;
  localparam logic [6:0] OP_LWU = 7'h10;
  localparam logic [6:0] OP_LHU = 7'h20;
  localparam logic [6:0] OP_LBU = 7'h40;

  logic        clk;
  logic        rst;
  logic        req_load;
  logic        req_store;
  logic [6:0]  rd_mem_op;
  logic [1:0]  st_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic [63:0] mem_rdata;
  logic        v64, v32, ack64, ack32;
  logic        sel32;

  logic        rdy64, mreq64, we64, wbv64, std64, err64;
  logic [63:0] maddr64, mwd64, wbd64;
  logic [7:0]  mask64;
  logic [4:0]  wbrd64;
  logic [1:0]  code64;

  logic        rdy32, mreq32, we32, wbv32, std32, err32;
  logic [31:0] maddr32, mwd32, wbd32;
  logic [3:0]  mask32;
  logic [4:0]  wbrd32;
  logic [1:0]  code32;

  lsu_ctrl #(.XLEN(64), .TIMEOUT(4)) u64 (
    .clk(clk), .rst(rst), .req_valid(v64), .req_ready(rdy64),
    .req_load(req_load), .req_store(req_store), .rd_mem_op(rd_mem_op),
    .st_size(st_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mreq64), .mem_we(we64), .mem_addr(maddr64), .mem_wdata(mwd64),
    .mem_wmask(mask64), .mem_ack(ack64), .mem_rdata(mem_rdata),
    .wb_valid(wbv64), .wb_rd(wbrd64), .wb_data(wbd64), .st_done(std64),
    .err(err64), .err_code(code64)
  );

  lsu_ctrl #(.XLEN(32), .TIMEOUT(4)) u32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32),
    .req_load(req_load), .req_store(req_store), .rd_mem_op(rd_mem_op),
    .st_size(st_size), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .req_rd(req_rd),
    .mem_req(mreq32), .mem_we(we32), .mem_addr(maddr32), .mem_wdata(mwd32),
    .mem_wmask(mask32), .mem_ack(ack32), .mem_rdata(mem_rdata[31:0]),
    .wb_valid(wbv32), .wb_rd(wbrd32), .wb_data(wbd32), .st_done(std32),
    .err(err32), .err_code(code32)
  );

  // Outputs of the instance currently under test.
  logic        t_rdy, t_mreq, t_we, t_wbv, t_std, t_err;
  logic [63:0] t_maddr, t_mwd, t_wbd;
  logic [7:0]  t_mask;
  logic [4:0]  t_wbrd;
  logic [1:0]  t_code;
  assign t_rdy   = sel32 ? rdy32  : rdy64;
  assign t_mreq  = sel32 ? mreq32 : mreq64;
  assign t_we    = sel32 ? we32   : we64;
  assign t_wbv   = sel32 ? wbv32  : wbv64;
  assign t_std   = sel32 ? std32  : std64;
  assign t_err   = sel32 ? err32  : err64;
  assign t_maddr = sel32 ? {32'h0, maddr32} : maddr64;
  assign t_mwd   = sel32 ? {32'h0, mwd32}   : mwd64;
  assign t_wbd   = sel32 ? {32'h0, wbd32}   : wbd64;
  assign t_mask  = sel32 ? {4'h0, mask32}   : mask64;
  assign t_wbrd  = sel32 ? wbrd32 : wbrd64;
  assign t_code  = sel32 ? code32 : code64;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_wb [2];

  typedef struct {
    logic        x32;
    logic        ld;
    logic        st;
    logic [6:0]  op;
    logic [1:0]  sz;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    int          dly;
    logic [1:0]  ecode;
    logic [63:0] eaddr;
    logic [7:0]  emask;
    logic [63:0] ewdata;
    logic [63:0] ewb;
  } vec_t;

  vec_t tv [27];

  function automatic vec_t mk(logic x32, logic ld, logic st, logic [6:0] op, logic [1:0] sz,
                              logic [63:0] addr, logic [63:0] wdata, logic [4:0] rd,
                              logic [63:0] rdata, int dly, logic [1:0] ecode,
                              logic [63:0] eaddr, logic [7:0] emask, logic [63:0] ewdata,
                              logic [63:0] ewb);
    vec_t v;
    v.x32 = x32; v.ld = ld; v.st = st; v.op = op; v.sz = sz; v.addr = addr;
    v.wdata = wdata; v.rd = rd; v.rdata = rdata; v.dly = dly; v.ecode = ecode;
    v.eaddr = eaddr; v.emask = emask; v.ewdata = ewdata; v.ewb = ewb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ack(input logic x32, input logic val);
    if (x32) ack32 = val;
    else ack64 = val;
  endtask

  // Apply one vector; entered and left at 1 ns after a rising edge, DUT idle.
  task automatic run_vec(input int idx, input vec_t v);
    int k;
    k = v.x32 ? 1 : 0;
    sel32 = v.x32;
    chk($sformatf("v%0d_idle_ready", idx), t_rdy, 1);
    req_load = v.ld; req_store = v.st; rd_mem_op = v.op; st_size = v.sz;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    if (v.x32) v32 = 1'b1;
    else v64 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0; req_load = 1'b0; req_store = 1'b0;
    if (v.ecode != 2'b00) begin
      chk($sformatf("v%0d_err", idx), t_err, 1);
      chk($sformatf("v%0d_err_code", idx), t_code, v.ecode);
      chk($sformatf("v%0d_no_mem_req", idx), t_mreq, 0);
      chk($sformatf("v%0d_busy", idx), t_rdy, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_err_clear", idx), {t_err, t_code}, 0);
      chk($sformatf("v%0d_ready_again", idx), t_rdy, 1);
      chk($sformatf("v%0d_wb_hold", idx), t_wbd, last_wb[k]);
    end else begin
      chk($sformatf("v%0d_mem_req", idx), t_mreq, 1);
      chk($sformatf("v%0d_mem_addr", idx), t_maddr, v.eaddr);
      chk($sformatf("v%0d_mem_we", idx), t_we, v.st);
      chk($sformatf("v%0d_mem_wmask", idx), t_mask, v.emask);
      if (v.st) chk($sformatf("v%0d_mem_wdata", idx), t_mwd, v.ewdata);
      for (int c = 0; c < v.dly; c++) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_req_held", idx), {t_mreq, t_err}, 2'b10);
      end
      mem_rdata = v.rdata;
      set_ack(v.x32, 1'b1);
      @(posedge clk); #1;
      set_ack(v.x32, 1'b0);
      mem_rdata = 64'h5555_5555_5555_5555;
      chk($sformatf("v%0d_wb_valid", idx), t_wbv, v.ld);
      chk($sformatf("v%0d_st_done", idx), t_std, v.st);
      chk($sformatf("v%0d_req_drop", idx), {t_mreq, t_err}, 0);
      if (v.ld) begin
        chk($sformatf("v%0d_wb_data", idx), t_wbd, v.ewb);
        chk($sformatf("v%0d_wb_rd", idx), t_wbrd, v.rd);
        last_wb[k] = v.ewb;
      end else begin
        chk($sformatf("v%0d_wb_hold_st", idx), t_wbd, last_wb[k]);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse_end", idx), {t_wbv, t_std}, 0);
      chk($sformatf("v%0d_ready_again", idx), t_rdy, 1);
      chk($sformatf("v%0d_wb_hold", idx), t_wbd, last_wb[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst = 1'b1; v64 = 1'b0; v32 = 1'b0; ack64 = 1'b0; ack32 = 1'b0; sel32 = 1'b0;
    req_load = 1'b0; req_store = 1'b0; rd_mem_op = 7'd0; st_size = 2'd0;
    req_addr = 64'd0; req_wdata = 64'd0; req_rd = 5'd0; mem_rdata = 64'd0;
    last_wb[0] = 64'd0; last_wb[1] = 64'd0;

    //        x32 ld st op      sz    addr                    wdata                     rd    rdata                      dly ec     eaddr        mask   ewdata                    ewb
    tv[0]  = mk(0, 1, 0, OP_LB,  2'd0, 64'h1003, 64'h0,                    5'd5,  64'h0000_0000_8000_0000, 0, 2'b00, 64'h1000, 8'h00, 64'h0,                    64'hFFFF_FFFF_FFFF_FF80);
    tv[1]  = mk(0, 1, 0, OP_LHU, 2'd0, 64'h2006, 64'h0,                    5'd6,  64'hBEEF_0000_0000_0000, 1, 2'b00, 64'h2000, 8'h00, 64'h0,                    64'h0000_0000_0000_BEEF);
    tv[2]  = mk(0, 1, 0, OP_LH,  2'd0, 64'h2006, 64'h0,                    5'd7,  64'hBEEF_0000_0000_0000, 0, 2'b00, 64'h2000, 8'h00, 64'h0,                    64'hFFFF_FFFF_FFFF_BEEF);
    tv[3]  = mk(0, 0, 1, 7'd0,   2'd2, 64'h3004, 64'h1234_5678,            5'd0,  64'h0,                   0, 2'b00, 64'h3000, 8'hF0, 64'h1234_5678_1234_5678, 64'h0);
    tv[4]  = mk(0, 1, 0, OP_LW,  2'd0, 64'h4002, 64'h0,                    5'd8,  64'h0,                   0, 2'b01, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[5]  = mk(0, 0, 1, 7'd0,   2'd0, 64'h5005, 64'hFFFF_FFFF_FFFF_FFAB,  5'd0,  64'h0,                   2, 2'b00, 64'h5000, 8'h20, 64'hABAB_ABAB_ABAB_ABAB, 64'h0);
    tv[6]  = mk(0, 0, 1, 7'd0,   2'd1, 64'h6002, 64'h0000_0000_0000_C0DE,  5'd0,  64'h0,                   0, 2'b00, 64'h6000, 8'h0C, 64'hC0DE_C0DE_C0DE_C0DE, 64'h0);
    tv[7]  = mk(0, 0, 1, 7'd0,   2'd3, 64'h7000, 64'h0123_4567_89AB_CDEF,  5'd0,  64'h0,                   1, 2'b00, 64'h7000, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
    tv[8]  = mk(0, 1, 0, OP_LD,  2'd0, 64'h8008, 64'h0,                    5'd9,  64'hDEAD_BEEF_CAFE_F00D, 0, 2'b00, 64'h8008, 8'h00, 64'h0,                    64'hDEAD_BEEF_CAFE_F00D);
    tv[9]  = mk(0, 1, 0, OP_LW,  2'd0, 64'h9004, 64'h0,                    5'd10, 64'h8765_4321_0000_0000, 0, 2'b00, 64'h9000, 8'h00, 64'h0,                    64'hFFFF_FFFF_8765_4321);
    tv[10] = mk(0, 1, 0, OP_LWU, 2'd0, 64'h9004, 64'h0,                    5'd11, 64'h8765_4321_0000_0000, 3, 2'b00, 64'h9000, 8'h00, 64'h0,                    64'h0000_0000_8765_4321);
    tv[11] = mk(0, 1, 0, OP_LBU, 2'd0, 64'hA001, 64'h0,                    5'd12, 64'h0000_0000_0000_F100, 0, 2'b00, 64'hA000, 8'h00, 64'h0,                    64'h0000_0000_0000_00F1);
    tv[12] = mk(0, 1, 0, OP_LH,  2'd0, 64'hB001, 64'h0,                    5'd13, 64'h0,                   0, 2'b01, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[13] = mk(0, 0, 1, 7'd0,   2'd3, 64'hC004, 64'h0,                    5'd0,  64'h0,                   0, 2'b01, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[14] = mk(0, 0, 1, 7'd0,   2'd1, 64'hC001, 64'h0,                    5'd0,  64'h0,                   0, 2'b01, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[15] = mk(0, 1, 1, OP_LB,  2'd0, 64'h0,    64'h0,                    5'd1,  64'h0,                   0, 2'b11, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[16] = mk(0, 0, 0, OP_LB,  2'd0, 64'h0,    64'h0,                    5'd1,  64'h0,                   0, 2'b11, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[17] = mk(0, 1, 0, 7'd0,   2'd0, 64'h0,    64'h0,                    5'd1,  64'h0,                   0, 2'b11, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[18] = mk(0, 1, 0, 7'h03,  2'd0, 64'h0,    64'h0,                    5'd1,  64'h0,                   0, 2'b11, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[19] = mk(0, 0, 1, 7'd0,   2'd2, 64'h3002, 64'h0,                    5'd0,  64'h0,                   0, 2'b01, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[20] = mk(1, 1, 0, OP_LD,  2'd0, 64'h100,  64'h0,                    5'd2,  64'h0,                   0, 2'b11, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[21] = mk(1, 1, 0, OP_LWU, 2'd0, 64'h100,  64'h0,                    5'd2,  64'h0,                   0, 2'b11, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[22] = mk(1, 0, 1, 7'd0,   2'd3, 64'h100,  64'h0,                    5'd0,  64'h0,                   0, 2'b11, 64'h0,    8'h00, 64'h0,                    64'h0);
    tv[23] = mk(1, 1, 0, OP_LW,  2'd0, 64'h104,  64'h0,                    5'd3,  64'h8000_0001,           0, 2'b00, 64'h104,  8'h00, 64'h0,                    64'h8000_0001);
    tv[24] = mk(1, 0, 1, 7'd0,   2'd0, 64'h103,  64'h5A,                   5'd0,  64'h0,                   1, 2'b00, 64'h100,  8'h08, 64'h5A5A_5A5A,            64'h0);
    tv[25] = mk(1, 1, 0, OP_LH,  2'd0, 64'h106,  64'h0,                    5'd4,  64'h8001_0000,           0, 2'b00, 64'h104,  8'h00, 64'h0,                    64'hFFFF_8001);
    tv[26] = mk(1, 1, 0, OP_LBU, 2'd0, 64'h101,  64'h0,                    5'd14, 64'h0000_7F00,           2, 2'b00, 64'h100,  8'h00, 64'h0,                    64'h7F);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state of both widths.
    for (int s = 0; s < 2; s++) begin
      sel32 = (s == 1);
      chk($sformatf("rst%0d_ready", s), t_rdy, 1);
      chk($sformatf("rst%0d_ctl", s), {t_mreq, t_we, t_wbv, t_std, t_err, t_code}, 0);
      chk($sformatf("rst%0d_mask", s), t_mask, 0);
      chk($sformatf("rst%0d_wb", s), {t_wbrd, t_wbd}, 0);
      chk($sformatf("rst%0d_maddr", s), t_maddr, 0);
    end

    for (int i = 0; i < 27; i++) run_vec(i, tv[i]);

    // Timeout: no ack, mem_req must stay up for exactly four cycles.
    sel32 = 1'b0;
    req_load = 1'b1; rd_mem_op = OP_LB; req_addr = 64'h100; req_rd = 5'd20; v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0; req_load = 1'b0;
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      if (!t_mreq) break;
      hi++;
      @(posedge clk); #1;
    end
    chk("tmo_req_cycles", hi, 4);
    chk("tmo_err", t_err, 1);
    chk("tmo_code", t_code, 2'b10);
    chk("tmo_no_wb", t_wbv, 0);
    @(posedge clk); #1;
    chk("tmo_ready", t_rdy, 1);
    chk("tmo_err_clear", t_err, 0);
    chk("tmo_wb_hold", t_wbd, last_wb[0]);

    // Reset while a request is outstanding; a late ack must be ignored.
    req_load = 1'b1; rd_mem_op = OP_LD; req_addr = 64'h200; req_rd = 5'd21; v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0; req_load = 1'b0;
    chk("mrst_req_up", t_mreq, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_req_drop", t_mreq, 0);
    chk("mrst_ready", t_rdy, 1);
    chk("mrst_wb_clear", t_wbd, 0);
    rst = 1'b0;
    ack64 = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    ack64 = 1'b0;
    chk("mrst_late_ack", {t_wbv, t_std, t_err, t_mreq}, 0);
    chk("mrst_ready_hold", t_rdy, 1);
    chk("mrst_wb_stays", t_wbd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
